regfile_wb_ctrl: RTL and testbench

- Write-side controller for the integer register file. It merges single-cycle ALU results and long-latency LSU load results into the single regfile write port (rd_wren / rd_addr / rd_data).
- Buffers LSU results in a small FIFO while the write port is busy.
- Keeps a pending-register scoreboard and reports read-after-write and write-after-write hazards to the decode stage.

---
 rtl/regfile_wb_ctrl.sv | 127 ++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-side controller: arbitrates ALU and LSU results onto one write port,
// buffers LSU results in a small FIFO and tracks pending long-latency destinations.
module regfile_wb_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  input  logic                     issue_long_i,
  input  logic [ADDR_W-1:0]        issue_rd_i,
  input  logic [ADDR_W-1:0]        rs1_addr_i,
  input  logic [ADDR_W-1:0]        rs2_addr_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  output logic                     stall_o,
  input  logic                     alu_valid_i,
  input  logic [ADDR_W-1:0]        alu_rd_i,
  input  logic [DATA_W-1:0]        alu_data_i,
  input  logic                     lsu_valid_i,
  input  logic [ADDR_W-1:0]        lsu_rd_i,
  input  logic [DATA_W-1:0]        lsu_data_i,
  output logic                     lsu_ready_o,
  output logic                     wb_wren_o,
  output logic [ADDR_W-1:0]        wb_rd_addr_o,
  output logic [DATA_W-1:0]        wb_data_o,
  output logic [(1<<ADDR_W)-1:0]   pending_o
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] fifo_rd_mem   [DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [DEPTH];

  logic [NREG-1:0]   pending_reg, pending_next, set_vec, clr_vec;
  logic              wb_wren_reg;
  logic [ADDR_W-1:0] wb_rd_addr_reg;
  logic [DATA_W-1:0] wb_data_reg;

  logic              fifo_empty, sel_any, sel_lsu, bypass, push, pop;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign fifo_empty  = (count_reg == '0);
  assign lsu_ready_o = (count_reg < CNT_W'(DEPTH));

  // Priority: ALU, then FIFO head, then direct LSU bypass when the FIFO is empty.
  assign pop     = !alu_valid_i && !fifo_empty;
  assign bypass  = !alu_valid_i && fifo_empty && lsu_valid_i;
  assign sel_lsu = pop || bypass;
  assign sel_any = alu_valid_i || sel_lsu;
  assign push    = lsu_valid_i && lsu_ready_o && !bypass;

  always_comb begin
    sel_rd   = alu_rd_i;
    sel_data = alu_data_i;
    if (pop) begin
      sel_rd   = fifo_rd_mem[rd_ptr_reg];
      sel_data = fifo_data_mem[rd_ptr_reg];
    end else if (bypass) begin
      sel_rd   = lsu_rd_i;
      sel_data = lsu_data_i;
    end
  end

  // Per-register scoreboard update; a set in the same cycle as a clear wins.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign set_vec[gi]      = 1'b0;
        assign clr_vec[gi]      = 1'b0;
        assign pending_next[gi] = 1'b0;
      end else begin : g_xn
        assign set_vec[gi] = issue_valid_i && issue_long_i && (issue_rd_i == ADDR_W'(gi));
        assign clr_vec[gi] = sel_lsu && (sel_rd == ADDR_W'(gi));
        assign pending_next[gi] = (pending_reg[gi] && !clr_vec[gi]) || set_vec[gi];
      end
    end
  endgenerate

  assign stall_o = ((rs1_addr_i != '0) && pending_reg[rs1_addr_i]) ||
                   ((rs2_addr_i != '0) && pending_reg[rs2_addr_i]) ||
                   ((rd_addr_i  != '0) && pending_reg[rd_addr_i]);

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg]   <= lsu_rd_i;
      fifo_data_mem[wr_ptr_reg] <= lsu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      pending_reg    <= '0;
      wb_wren_reg    <= 1'b0;
      wb_rd_addr_reg <= '0;
      wb_data_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
      pending_reg <= pending_next;
      // x0 writes consume their source but never assert the enable.
      if (sel_any) begin
        wb_wren_reg    <= (sel_rd != '0);
        wb_rd_addr_reg <= sel_rd;
        wb_data_reg    <= sel_data;
      end else begin
        wb_wren_reg    <= 1'b0;
      end
    end
  end

  assign wb_wren_o    = wb_wren_reg;
  assign wb_rd_addr_o = wb_rd_addr_reg;
  assign wb_data_o    = wb_data_reg;
  assign pending_o    = pending_reg;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_regfile_wb_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              issue_valid_i, issue_long_i;
  logic [ADDR_W-1:0] issue_rd_i, rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic              stall_o;
  logic              alu_valid_i;
  logic [ADDR_W-1:0] alu_rd_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              lsu_valid_i;
  logic [ADDR_W-1:0] lsu_rd_i;
  logic [DATA_W-1:0] lsu_data_i;
  logic              lsu_ready_o;
  logic              wb_wren_o;
  logic [ADDR_W-1:0] wb_rd_addr_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [31:0]       pending_o;

  regfile_wb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_long_i(issue_long_i), .issue_rd_i(issue_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .stall_o(stall_o),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .lsu_ready_o(lsu_ready_o),
    .wb_wren_o(wb_wren_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
    .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: LSU results in a queue, pending registers as a bit set.
  int          mq_rd[$];
  logic [31:0] mq_data[$];
  logic [31:0] m_pend = '0;
  logic        m_wren = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_rdy, m_have, m_from_lsu, m_byp;
  int          w_rd;
  logic [31:0] w_data;

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        mq_rd.delete(); mq_data.delete();
        m_pend = '0; m_wren = 1'b0; m_addr = '0; m_data = '0;
      end else begin
        m_rdy = (mq_rd.size() < DEPTH);
        m_have = 0; m_from_lsu = 0; m_byp = 0;
        w_rd = 0; w_data = '0;
        if (alu_valid_i) begin
          m_have = 1; w_rd = alu_rd_i; w_data = alu_data_i;
        end else if (mq_rd.size() > 0) begin
          m_have = 1; m_from_lsu = 1;
          w_rd = mq_rd.pop_front(); w_data = mq_data.pop_front();
        end else if (lsu_valid_i) begin
          m_have = 1; m_from_lsu = 1; m_byp = 1;
          w_rd = lsu_rd_i; w_data = lsu_data_i;
        end
        if (lsu_valid_i && m_rdy && !m_byp) begin
          mq_rd.push_back(lsu_rd_i); mq_data.push_back(lsu_data_i);
        end
        if (m_from_lsu) m_pend[w_rd] = 1'b0;
        if (issue_valid_i && issue_long_i && issue_rd_i != 0) m_pend[issue_rd_i] = 1'b1;
        m_wren = m_have && (w_rd != 0);
        if (m_have) begin
          m_addr = 5'(w_rd); m_data = w_data;
        end
      end
    end
  end

  logic exp_stall;
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        chk("model_wren", wb_wren_o, m_wren);
        if (m_wren) begin
          chk("model_addr", wb_rd_addr_o, m_addr);
          chk("model_data", wb_data_o, m_data);
        end
        chk("model_pending", pending_o, m_pend);
        chk("model_ready", lsu_ready_o, (mq_rd.size() < DEPTH));
        exp_stall = (rs1_addr_i != 0 && m_pend[rs1_addr_i]) ||
                    (rs2_addr_i != 0 && m_pend[rs2_addr_i]) ||
                    (rd_addr_i  != 0 && m_pend[rd_addr_i]);
        chk("model_stall", stall_o, exp_stall);
      end
    end
  end

  // Log of observed writes (address and cycle) for ordering checks.
  int log_addr[$];
  int log_cyc[$];
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && wb_wren_o) begin
        log_addr.push_back(wb_rd_addr_o);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic idle();
    issue_valid_i = 0; issue_long_i = 0; issue_rd_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0;
    alu_valid_i = 0; alu_rd_i = '0; alu_data_i = '0;
    lsu_valid_i = 0; lsu_rd_i = '0; lsu_data_i = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic issue_long(input logic [ADDR_W-1:0] rd);
    issue_valid_i = 1; issue_long_i = 1; issue_rd_i = rd;
    tick();
    issue_valid_i = 0; issue_long_i = 0; issue_rd_i = '0;
  endtask

  int acc, acc_alu, first_log, k, prev_cyc;
  int lsu_addrs[$];
  int lsu_cycs[$];

  initial begin
    idle();
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_wren", wb_wren_o, 0);
    chk("rst_addr", wb_rd_addr_o, 0);
    chk("rst_data", wb_data_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_ready", lsu_ready_o, 1);
    chk("rst_stall", stall_o, 0);
    @(posedge clk_i); #2;
    rst_ni = 1;
    tick();

    // Bypass with scoreboard clear
    issue_long(5);
    chk("byp_pend_set", pending_o, 32'h0000_0020);
    rs1_addr_i = 5; #1;
    chk("byp_stall_pre", stall_o, 1);
    rs1_addr_i = 0;
    lsu_valid_i = 1; lsu_rd_i = 5; lsu_data_i = 32'hDEAD_BEEF;
    tick();
    idle();
    chk("byp_wren", wb_wren_o, 1);
    chk("byp_addr", wb_rd_addr_o, 5);
    chk("byp_data", wb_data_o, 32'hDEAD_BEEF);
    chk("byp_pend_clr", pending_o, 0);
    tick();

    // Contention: ALU holds the port for 6 cycles while LSU offers 5 results
    acc = 0; acc_alu = 0; first_log = log_addr.size();
    for (int c = 0; c < 14; c++) begin
      alu_valid_i = (c < 6); alu_rd_i = 3; alu_data_i = 32'h11;
      if (acc < 5) begin
        lsu_valid_i = 1; lsu_rd_i = 5'(7 + acc); lsu_data_i = 32'hA000_0000 + 32'(7 + acc);
      end else begin
        lsu_valid_i = 0;
      end
      #1;
      if (c == 4) chk("cont_ready_full", lsu_ready_o, 0);
      if (c == 6) chk("cont_ready_full_pop", lsu_ready_o, 0);
      if (lsu_valid_i && lsu_ready_o) begin
        acc++;
        if (c < 6) acc_alu++;
      end
      tick();
    end
    idle();
    chk("cont_accepted_during_alu", acc_alu, 4);
    for (int i = first_log; i < log_addr.size(); i++) begin
      if (log_addr[i] != 3) begin
        lsu_addrs.push_back(log_addr[i]);
        lsu_cycs.push_back(log_cyc[i]);
      end
    end
    chk("cont_lsu_write_count", lsu_addrs.size(), 5);
    for (int i = 0; i < 5 && i < lsu_addrs.size(); i++) begin
      chk("cont_order", lsu_addrs[i], 7 + i);
      if (i > 0) chk("cont_consecutive", lsu_cycs[i] - lsu_cycs[i-1], 1);
    end

    // RAW / WAW hazard on a long-latency destination
    issue_long(12);
    rs1_addr_i = 12; rs2_addr_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("haz_stall_wait", stall_o, 1);
      tick();
    end
    rs1_addr_i = 0; rd_addr_i = 12; #1;
    chk("haz_stall_waw", stall_o, 1);
    rd_addr_i = 0; #1;
    chk("haz_x0_nostall", stall_o, 0);
    rs1_addr_i = 12;
    lsu_valid_i = 1; lsu_rd_i = 12; lsu_data_i = 32'h0000_000C;
    tick();
    lsu_valid_i = 0; #1;
    chk("haz_wb_wren", wb_wren_o, 1);
    chk("haz_wb_addr", wb_rd_addr_o, 12);
    chk("haz_stall_drop", stall_o, 0);
    idle();
    tick();

    // Set and clear of the same register in one cycle
    issue_long(4);
    lsu_valid_i = 1; lsu_rd_i = 4; lsu_data_i = 32'h44;
    issue_valid_i = 1; issue_long_i = 1; issue_rd_i = 4;
    tick();
    idle();
    chk("coll_wren", wb_wren_o, 1);
    chk("coll_addr", wb_rd_addr_o, 4);
    chk("coll_pending", pending_o, 32'h0000_0010);
    lsu_valid_i = 1; lsu_rd_i = 4; lsu_data_i = 32'h45;
    tick();
    idle();
    chk("coll_pending_clr", pending_o, 0);

    // x0 result queued behind an ALU write, then consumed silently
    alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h22;
    lsu_valid_i = 1; lsu_rd_i = 0; lsu_data_i = 32'hFFFF_FFFF;
    tick();
    idle();
    #1;
    chk("x0_stall", stall_o, 0);
    tick();
    chk("x0_wren", wb_wren_o, 0);
    lsu_valid_i = 1; lsu_rd_i = 6; lsu_data_i = 32'h66;
    tick();
    idle();
    chk("x0_after_wren", wb_wren_o, 1);
    chk("x0_after_addr", wb_rd_addr_o, 6);
    tick();

    // Asynchronous reset with three FIFO entries held
    issue_long(1);
    issue_long(2);
    issue_long(7);
    chk("mid_pending", pending_o, 32'h0000_0086);
    alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h33;
    for (int i = 0; i < 3; i++) begin
      lsu_valid_i = 1; lsu_rd_i = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd7;
      lsu_data_i = 32'hB0 + 32'(i);
      tick();
    end
    lsu_valid_i = 0;
    tick();
    #2;
    rst_ni = 0;
    #1;
    chk("mid_rst_wren", wb_wren_o, 0);
    chk("mid_rst_addr", wb_rd_addr_o, 0);
    chk("mid_rst_data", wb_data_o, 0);
    chk("mid_rst_pending", pending_o, 0);
    chk("mid_rst_ready", lsu_ready_o, 1);
    idle();
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_post_wren", wb_wren_o, 0);
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
